// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the mar810 bus arbiter: bus widths, FSM/port enums, request payload.
// Latency: n/a (types only).
// Backpressure: n/a.
package core_bus_arbiter_pkg;

  typedef logic [29:0] ptr;     // word address
  typedef logic [31:0] word;
  typedef logic [3:0]  nibble;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_INSN = 1'b0,
    PORT_DATA = 1'b1
  } arb_port_t;

  // Everything a port hands to the master for one transaction.
  typedef struct packed {
    ptr    addr;
    logic  write;
    word   wdata;
    nibble be;
  } arb_req_t;

  localparam nibble BE_ALL = 4'hF;

  // Saturating +1 for the optional performance counters.
  function automatic word sat_inc(input word v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Single-entry request latch: remembers one start pulse and its payload until granted.
// Latency: pend_o rises the cycle after start_i.
// Backpressure: none; a start while pending overwrites the held request.
module arb_req_latch
  import core_bus_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     start_i,
  input  arb_req_t req_i,
  input  logic     clear_i,
  output logic     pend_o,
  output arb_req_t held_o
);

  logic     pend_q;
  arb_req_t held_q;

  // A new start wins over a same-cycle clear so a request is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      held_q <= '0;
    end else if (start_i) begin
      pend_q <= 1'b1;
      held_q <= req_i;
    end else if (clear_i) begin
      pend_q <= 1'b0;
    end
  end

  assign pend_o = pend_q;
  assign held_o = held_q;

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin share of one platform master between the core's fetch and data ports.
// Latency: start at N -> master_start at N+2; *_ready is combinational from master_ready.
// Backpressure: one outstanding master transaction; each port holds one queued request.
// Optional: define ARB_PERF_EN for grant/stall counters exposed as perf_* ports.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  insn_start,
  input  ptr    insn_addr,
  output logic  insn_ready,
  output word   insn_data_rd,
  input  logic  data_start,
  input  ptr    data_addr,
  input  logic  data_write,
  input  word   data_data_wr,
  input  nibble data_data_be,
  output logic  data_ready,
  output word   data_data_rd,
  output logic  master_start,
  output ptr    master_addr,
  output logic  master_write,
  output word   master_data_wr,
  output nibble master_data_be,
  input  logic  master_ready,
  input  word   master_data_rd
`ifdef ARB_PERF_EN
  ,
  output logic [31:0] perf_insn_grants,
  output logic [31:0] perf_data_grants,
  output logic [31:0] perf_stall_cycles
`endif
);

  arb_state_t state_q, state_d;
  arb_port_t  last_q, last_d;
  logic       grant_i, grant_d;
  logic       insn_pend, data_pend;
  arb_req_t   insn_req, data_req, insn_held, data_held;
  logic       mstart_q;
  arb_req_t   mreq_q;

  // Fetches are always full-word reads.
  assign insn_req = '{addr: insn_addr, write: 1'b0, wdata: 32'h0, be: BE_ALL};
  assign data_req = '{addr: data_addr, write: data_write, wdata: data_data_wr, be: data_data_be};

  arb_req_latch u_insn_latch (
    .clk(clk), .rst(rst), .start_i(insn_start), .req_i(insn_req),
    .clear_i(grant_i), .pend_o(insn_pend), .held_o(insn_held)
  );

  arb_req_latch u_data_latch (
    .clk(clk), .rst(rst), .start_i(data_start), .req_i(data_req),
    .clear_i(grant_d), .pend_o(data_pend), .held_o(data_held)
  );

  // State, round-robin pointer and registered master request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= PORT_INSN;
      mstart_q <= 1'b0;
      mreq_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      mstart_q <= grant_i | grant_d;
      if (grant_i) begin
        mreq_q <= insn_held;
      end else if (grant_d) begin
        mreq_q <= data_held;
      end
    end
  end

  // Grant only from IDLE; when both wait, the port not served last goes first.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (insn_pend && (!data_pend || last_q == PORT_DATA)) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
          last_d  = PORT_INSN;
        end else if (data_pend) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
          last_d  = PORT_DATA;
        end
      end
      BUSY_I, BUSY_D: begin
        if (master_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign master_start   = mstart_q;
  assign master_addr    = mreq_q.addr;
  assign master_write   = mreq_q.write;
  assign master_data_wr = mreq_q.wdata;
  assign master_data_be = mreq_q.be;

  // A ready seen in IDLE (stale after reset) reaches neither port.
  assign insn_ready   = master_ready & (state_q == BUSY_I);
  assign data_ready   = master_ready & (state_q == BUSY_D);
  assign insn_data_rd = master_data_rd;
  assign data_data_rd = master_data_rd;

`ifdef ARB_PERF_EN
  logic [31:0] perf_ig_q, perf_dg_q, perf_st_q;

  // Saturating grant counters and a per-cycle "someone is waiting" counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ig_q <= 32'h0;
      perf_dg_q <= 32'h0;
      perf_st_q <= 32'h0;
    end else begin
      if (grant_i) perf_ig_q <= sat_inc(perf_ig_q);
      if (grant_d) perf_dg_q <= sat_inc(perf_dg_q);
      if ((insn_pend && !grant_i) || (data_pend && !grant_d)) perf_st_q <= sat_inc(perf_st_q);
    end
  end

  assign perf_insn_grants  = perf_ig_q;
  assign perf_data_grants  = perf_dg_q;
  assign perf_stall_cycles = perf_st_q;
`endif

`ifndef SYNTHESIS
  // A port may not restart while its previous request is still queued or in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(insn_start && (insn_pend || (state_q == BUSY_I && !master_ready))));
      assert (!(data_start && (data_pend || (state_q == BUSY_D && !master_ready))));
    end
  end
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench for core_bus_arbiter: directed stimulus, platform model, decoupled monitors.
// Latency: expectations carry the exact cycle of each master_start and *_ready.
// Backpressure: platform answers every request two cycles after master_start.
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  insn_start, data_start, data_write;
  ptr    insn_addr, data_addr;
  word   data_data_wr;
  nibble data_data_be;
  logic  insn_ready, data_ready;
  word   insn_data_rd, data_data_rd;
  logic  master_start, master_write, master_ready;
  ptr    master_addr;
  word   master_data_wr, master_data_rd;
  nibble master_data_be;
`ifdef ARB_PERF_EN
  logic [31:0] perf_insn_grants, perf_data_grants, perf_stall_cycles;
`endif

  core_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .insn_start(insn_start), .insn_addr(insn_addr),
    .insn_ready(insn_ready), .insn_data_rd(insn_data_rd),
    .data_start(data_start), .data_addr(data_addr), .data_write(data_write),
    .data_data_wr(data_data_wr), .data_data_be(data_data_be),
    .data_ready(data_ready), .data_data_rd(data_data_rd),
    .master_start(master_start), .master_addr(master_addr), .master_write(master_write),
    .master_data_wr(master_data_wr), .master_data_be(master_data_be),
    .master_ready(master_ready), .master_data_rd(master_data_rd)
`ifdef ARB_PERF_EN
    ,
    .perf_insn_grants(perf_insn_grants), .perf_data_grants(perf_data_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [29:0] addr;
    logic        write;
    logic [31:0] wd;
    logic [3:0]  be;
  } mexp_t;

  typedef struct {
    int          cyc;
    bit          is_data;
    logic [31:0] rd;
  } rexp_t;

  mexp_t mq[$];
  rexp_t rq[$];

  bit plat_en   = 1'b1;
  bit stray_rdy = 1'b0;
  bit plat_real = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] plat_rd(input logic [29:0] a);
    return (a == 30'h100) ? 32'hDEAD_BEEF : {a, 2'b01};
  endfunction

  // Platform model: answers each request two cycles after its master_start.
  initial begin : platform
    bit          busy = 1'b0;
    int          resp_cyc = 0;
    logic [29:0] resp_addr = '0;
    master_ready   = 1'b0;
    master_data_rd = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      master_ready   = 1'b0;
      master_data_rd = 32'h0;
      plat_real      = 1'b0;
      if (plat_en && master_start) begin
        busy      = 1'b1;
        resp_cyc  = cyc + 2;
        resp_addr = master_addr;
      end
      if (busy && cyc == resp_cyc) begin
        master_ready   = 1'b1;
        master_data_rd = plat_rd(resp_addr);
        plat_real      = 1'b1;
        busy           = 1'b0;
      end
      if (stray_rdy) begin
        master_ready   = 1'b1;
        master_data_rd = 32'h0BAD_0BAD;
      end
    end
  end

  // Monitor: pops master-request and completion expectations as the DUT presents them.
  initial begin : monitor
    mexp_t e, last_e;
    rexp_t r;
    last_e = '{0, '0, 1'b0, '0, '0};
    forever begin
      @(negedge clk);
      if (master_start) begin
        if (mq.size() == 0) begin
          chk("unexpected_master_start", 1, 0);
        end else begin
          e = mq.pop_front();
          chk("mst_cycle", cyc, e.cyc);
          chk("mst_addr", master_addr, e.addr);
          chk("mst_write", master_write, e.write);
          chk("mst_wdata", master_data_wr, e.wd);
          chk("mst_be", master_data_be, e.be);
          last_e = e;
        end
      end
      if (master_ready && plat_real) begin
        chk("hold_addr", master_addr, last_e.addr);
        chk("hold_be", master_data_be, last_e.be);
      end
      if (insn_ready || data_ready) begin
        if (insn_ready && data_ready) chk("both_ready", 1, 0);
        if (rq.size() == 0) begin
          chk("unexpected_ready", {insn_ready, data_ready}, 0);
        end else begin
          r = rq.pop_front();
          chk("rsp_port_is_data", data_ready, r.is_data);
          chk("rsp_cycle", cyc, r.cyc);
          chk("rsp_data", data_ready ? data_data_rd : insn_data_rd, r.rd);
        end
      end
    end
  end

  // Watchdog: the directed sequence is a few hundred cycles long.
  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired at %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_master_start"}, master_start, 0);
    chk({tag, "_master_addr"}, master_addr, 0);
    chk({tag, "_master_write"}, master_write, 0);
    chk({tag, "_master_wdata"}, master_data_wr, 0);
    chk({tag, "_master_be"}, master_data_be, 0);
    chk({tag, "_ready"}, {insn_ready, data_ready}, 0);
    chk({tag, "_rd"}, {insn_data_rd, data_data_rd}, 0);
  endtask

  task automatic push_m(input int c, input logic [29:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] be);
    mexp_t e;
    e = '{c, a, w, wd, be};
    mq.push_back(e);
  endtask

  task automatic push_r(input int c, input bit is_d, input logic [31:0] rd);
    rexp_t r;
    r = '{c, is_d, rd};
    rq.push_back(r);
  endtask

  // Directed stimulus.
  initial begin : stim
    int n;
    rst = 1'b1;
    insn_start = 1'b0; insn_addr = '0;
    data_start = 1'b0; data_addr = '0; data_write = 1'b0;
    data_data_wr = '0; data_data_be = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick(); tick();

    // Single uncontended fetch.
    n = cyc;
    insn_start = 1'b1; insn_addr = 30'h100;
    push_m(n + 2, 30'h100, 1'b0, 32'h0, 4'hF);
    push_r(n + 4, 1'b0, 32'hDEAD_BEEF);
    tick();
    insn_start = 1'b0;
    repeat (8) tick();

    // Simultaneous starts right after reset: data first, insn two cycles after its ready.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    n = cyc;
    insn_start = 1'b1; insn_addr = 30'h40;
    data_start = 1'b1; data_addr = 30'h20; data_write = 1'b1;
    data_data_wr = 32'h1234_5678; data_data_be = 4'h3;
    push_m(n + 2, 30'h20, 1'b1, 32'h1234_5678, 4'h3);
    push_m(n + 6, 30'h40, 1'b0, 32'h0, 4'hF);
    push_r(n + 4, 1'b1, 32'h0000_0081);
    push_r(n + 8, 1'b0, 32'h0000_0101);
    tick();
    insn_start = 1'b0; data_start = 1'b0; data_write = 1'b0;
    repeat (10) tick();
`ifdef ARB_PERF_EN
    chk("perf_data_grants", perf_data_grants, 1);
    chk("perf_insn_grants", perf_insn_grants, 1);
    chk("perf_stall_cycles", perf_stall_cycles, 4);
`endif

    // Saturated alternating traffic: each port restarts on the cycle of its own ready.
    n = cyc;
    for (int t = 0; t <= 400; t++) begin
      insn_start = 1'b0; data_start = 1'b0;
      for (int k = 0; k < 100; k++) begin
        int issue;
        issue = (k < 2) ? 0 : 4 * k - 4;
        if (issue == t) begin
          if (k % 2 == 0) begin
            data_start = 1'b1; data_addr = 30'h1000 + k; data_write = 1'b1;
            data_data_wr = 32'hC0DE_0000 | k; data_data_be = 4'h5;
            push_m(n + 2 + 4 * k, 30'h1000 + k, 1'b1, 32'hC0DE_0000 | k, 4'h5);
            push_r(n + 4 + 4 * k, 1'b1, {30'h1000 + k, 2'b01});
          end else begin
            insn_start = 1'b1; insn_addr = 30'h1000 + k;
            push_m(n + 2 + 4 * k, 30'h1000 + k, 1'b0, 32'h0, 4'hF);
            push_r(n + 4 + 4 * k, 1'b0, {30'h1000 + k, 2'b01});
          end
        end
      end
      tick();
    end
    insn_start = 1'b0; data_start = 1'b0; data_write = 1'b0;
    repeat (5) tick();

    // Reset while BUSY_D: outputs clear, a later stray ready is not forwarded.
    plat_en = 1'b0;
    n = cyc;
    data_start = 1'b1; data_addr = 30'h3FF; data_write = 1'b1;
    data_data_wr = 32'hA5A5_A5A5; data_data_be = 4'hC;
    push_m(n + 2, 30'h3FF, 1'b1, 32'hA5A5_A5A5, 4'hC);
    tick();
    data_start = 1'b0; data_write = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check_zero("midreset");
    rst = 1'b0;
    tick();
    stray_rdy = 1'b1;
    tick();
    stray_rdy = 1'b0;
    chk("stray_master_ready_seen", master_ready, 1);
    chk("stray_no_ready", {insn_ready, data_ready}, 0);
    repeat (3) tick();
    plat_en = 1'b1;

    // Fetch restarted on the very cycle of its own completion.
    n = cyc;
    insn_start = 1'b1; insn_addr = 30'h55;
    push_m(n + 2, 30'h55, 1'b0, 32'h0, 4'hF);
    push_r(n + 4, 1'b0, 32'h0000_0155);
    tick();
    insn_start = 1'b0;
    tick(); tick(); tick();
    chk("own_ready_now", insn_ready, 1);
    insn_start = 1'b1; insn_addr = 30'h66;
    push_m(n + 6, 30'h66, 1'b0, 32'h0, 4'hF);
    push_r(n + 8, 1'b0, 32'h0000_0199);
    tick();
    insn_start = 1'b0;
    repeat (8) tick();

    chk("master_queue_drained", mq.size(), 0);
    chk("resp_queue_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Shares one bus master port between the mar810 core's instruction-fetch and data ports, so a single platform master can serve both. Each port's one-cycle start request is latched and serialized onto the master port. Grants alternate round-robin, and completions are routed back to the originating port. The block sits between the core (or the L1I refill side) and the platform master.

## Interface
Parameters:
- none; widths come from the shared `types.sv` (`ptr` = 30-bit word address, `word` = 32 bits, `nibble` = 4 bits)

Ports:
- `clk` in 1: single clock; one clock domain; reset is synchronous and active-high
- `rst` in 1: synchronous, active-high reset
- `insn_start` in 1: one-cycle fetch request pulse
- `insn_addr` in ptr: fetch address, sampled with `insn_start`
- `insn_ready` out 1: one-cycle fetch completion pulse
- `insn_data_rd` out word: fetch data, valid while `insn_ready` is high
- `data_start` in 1: one-cycle data request pulse
- `data_addr` in ptr: data address, sampled with `data_start`
- `data_write` in 1: 1 = store, sampled with `data_start`
- `data_data_wr` in word: store data, sampled with `data_start`
- `data_data_be` in nibble: byte enables, sampled with `data_start`
- `data_ready` out 1: one-cycle data completion pulse
- `data_data_rd` out word: load data, valid while `data_ready` is high
- `master_start` out 1: one-cycle request pulse to the platform
- `master_addr` out ptr: request address
- `master_write` out 1: request is a store
- `master_data_wr` out word: store data
- `master_data_be` out nibble: byte enables; 4'b1111 for fetches
- `master_ready` in 1: platform completion pulse
- `master_data_rd` in word: platform read data

## Operation
- One request latch per port.
  - A start pulse sets `pend` and captures address and payload.
  - The latch clears when its request is granted.
- FSM states: IDLE, BUSY_I, BUSY_D.
  - IDLE with ≥1 pending: grant and go to BUSY_I or BUSY_D. `master_start` and `master_*` are registered and asserted on the cycle after the grant.
  - BUSY_x: wait for `master_ready`, then return to IDLE.
- Arbitration is round-robin via `last` (0 = insn, 1 = data; reset value 0, so data wins first).
  - Both pending: grant the port other than `last`.
  - Only one pending: grant it; `last` updates on every grant.
- Completion is combinational pass-through gated by state.
  - `insn_ready` = `master_ready` & BUSY_I.
  - `data_ready` = `master_ready` & BUSY_D.
  - `*_data_rd` = `master_data_rd`.
- `master_ready` in IDLE is ignored; it can only be stale after a reset.
- Start on a port already pending or in flight is a protocol violation: it raises a simulation-only assertion and the new request overwrites the latch.
- Start on a port in the same cycle its previous request completes is legal and is latched.

## Timing
- Reset values: all outputs 0, FSM in IDLE, both `pend` = 0, `last` = 0.
- Uncontended latency: start at cycle N, then latch (N+1), grant, `master_start` at N+2. Ready is zero-cycle from `master_ready`.
- Back-to-back requests:
  - `master_ready` at cycle M with the other port pending gives the next `master_start` at M+2, one IDLE cycle.
  - Minimum master turnaround is 2 cycles.
- Simultaneous starts in IDLE are both latched; the port other than `last` issues first. The second issues 2 cycles after the first completes.
- Reset mid-transaction:
  - Everything clears and `master_start` drops.
  - The abandoned request is never acknowledged.
  - The platform must tolerate a dropped transaction.
- `master_start` is high exactly one cycle per grant; `master_*` payload is held stable until `master_ready`.

## Configuration
- `ARB_PERF_EN` defined: adds three 32-bit saturating counters, all reset to 0.
  - `perf_insn_grants`, `perf_data_grants`: increment on each grant.
  - `perf_stall_cycles`: increments on each cycle where a `pend` is set and not granted that cycle.
  - The counters are also output ports.
- Undefined: no counters and no perf ports; all other behaviour is identical.

## Structure
- Add `arb_state_t` (IDLE, BUSY_I, BUSY_D) and `arb_port_t` (PORT_INSN, PORT_DATA) to `types.sv`.
- Sub-module `arb_req_latch`, instantiated twice:
  - Inputs: start, payload, clear.
  - Outputs: pend and held payload.
  - The insn instance ties write to 0 and byte enables to 4'b1111.

## Test plan
- Reset, then a single `insn_start` with addr 0x100: `master_start` 2 cycles later with addr 0x100, write 0, be 4'hF. `master_ready` with rd 0xDEADBEEF gives `insn_ready` the same cycle with 0xDEADBEEF.
- Both starts in the same cycle after reset (data addr 0x20, store 0x12345678, be 4'h3): data is issued first. Insn issues 2 cycles after data's `master_ready`. `data_ready` never pulses for the insn completion.
- Continuous alternating traffic for 100 requests: grants strictly alternate and no port waits more than one master transaction.
- `rst` asserted while BUSY_D: all outputs are 0 next cycle. A later stray `master_ready` produces no `*_ready`.
- `insn_start` in the same cycle as its own `insn_ready`: the new request is issued 2 cycles later.
- With `ARB_PERF_EN`: after test 2, `perf_data_grants` = 1, `perf_insn_grants` = 1, and `perf_stall_cycles` equals the cycles insn waited.
